// File: rtl/axis_cntr_pkg.sv
// Shared definitions for the counter-pattern AXI4-Stream generator/checker pair.
package axis_cntr_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } cntr_state_e;

  localparam int          DEF_PACK_SIZE = 1024;
  localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;

  // Right-shifting Fibonacci form of taps 16,14,13,11: feedback from bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {^(cur & LFSR_TAP_MASK), cur[15:1]};
  endfunction

endpackage

// File: rtl/axis_ready_lfsr.sv
// 16-bit Fibonacci LFSR used to produce a pseudo-random tready pattern.
module axis_ready_lfsr
  import axis_cntr_pkg::*;
#(
  parameter logic [15:0] SEED = DEF_LFSR_SEED
) (
  input  logic clk_i,
  input  logic s_rst_i,
  input  logic en_i,
  output logic ready_bit_o
);

  logic [15:0] lfsr_q, lfsr_d;

  // Advance one step whenever enabled, otherwise hold.
  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) lfsr_d = lfsr_next(lfsr_q);
  end

  // Shift register, reloaded with the seed on reset.
  always_ff @(posedge clk_i) begin
    if (s_rst_i) lfsr_q <= SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign ready_bit_o = lfsr_q[0];

endmodule

// File: rtl/axis_data_checker_cntr.sv
// AXI4-Stream sink that checks a 0..PACK_SIZE-1 counter pattern per packet.
//
//   state    | meaning
//   ST_IDLE  | stopped, tready held low
//   ST_RUN   | accepting beats, tready from LFSR or constant high
module axis_data_checker_cntr
  import axis_cntr_pkg::*;
#(
  parameter int                            AXIS_DATA_WIDTH = 32,
  parameter logic [AXIS_DATA_WIDTH/8-1:0]  AXIS_TKEEP      = {AXIS_DATA_WIDTH/8{1'b1}},
  parameter int                            PACK_SIZE       = DEF_PACK_SIZE,
  parameter int                            CNT_WIDTH       = 32,
  parameter logic [15:0]                   LFSR_SEED       = DEF_LFSR_SEED
) (
  input  logic                         clk_i,
  input  logic                         s_rst_i,
  input  logic                         enable_i,
  input  logic                         clear_i,
  input  logic                         backpressure_en_i,
  input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata_i,
  input  logic [AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep_i,
  input  logic                         s_axis_tvalid_i,
  input  logic                         s_axis_tlast_i,
  output logic                         s_axis_tready_o,
  output logic [CNT_WIDTH-1:0]         packet_count_o,
  output logic [CNT_WIDTH-1:0]         data_err_count_o,
  output logic [CNT_WIDTH-1:0]         last_err_count_o,
  output logic [CNT_WIDTH-1:0]         keep_err_count_o,
  output logic                         error_o,
  output logic [AXIS_DATA_WIDTH-1:0]   first_err_expected_o,
  output logic [AXIS_DATA_WIDTH-1:0]   first_err_received_o,
  output logic [CNT_WIDTH-1:0]         first_err_packet_o
);

  localparam int IDX_W = $clog2(PACK_SIZE);

  cntr_state_e                state_q, state_d;
  logic                       tready_q, tready_d;
  logic                       lfsr_en, lfsr_bit;
  logic [IDX_W-1:0]           beat_idx_q, beat_idx_d;
  logic [CNT_WIDTH-1:0]       pkt_cnt_q, pkt_cnt_d;
  logic [CNT_WIDTH-1:0]       data_err_q, data_err_d;
  logic [CNT_WIDTH-1:0]       last_err_q, last_err_d;
  logic [CNT_WIDTH-1:0]       keep_err_q, keep_err_d;
  logic                       error_q, error_d;
  logic [AXIS_DATA_WIDTH-1:0] fe_exp_q, fe_exp_d;
  logic [AXIS_DATA_WIDTH-1:0] fe_rcv_q, fe_rcv_d;
  logic [CNT_WIDTH-1:0]       fe_pkt_q, fe_pkt_d;

  logic                       accept;
  logic [AXIS_DATA_WIDTH-1:0] expected;
  logic                       is_final, data_bad, keep_bad, last_bad;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  axis_ready_lfsr #(.SEED(LFSR_SEED)) u_ready_lfsr (
    .clk_i       (clk_i),
    .s_rst_i     (s_rst_i),
    .en_i        (lfsr_en),
    .ready_bit_o (lfsr_bit)
  );

  // Run/stop sequencing and next tready value; the LFSR only steps while tready is being loaded.
  always_comb begin
    state_d  = state_q;
    tready_d = 1'b0;
    lfsr_en  = 1'b0;
    case (state_q)
      ST_IDLE: if (enable_i) state_d = ST_RUN;
      ST_RUN: begin
        if (!enable_i) begin
          state_d = ST_IDLE;
        end else begin
          lfsr_en  = 1'b1;
          tready_d = backpressure_en_i ? lfsr_bit : 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept   = s_axis_tvalid_i & tready_q;
  assign expected = AXIS_DATA_WIDTH'(beat_idx_q);
  assign is_final = (beat_idx_q == IDX_W'(PACK_SIZE - 1));
  assign data_bad = (s_axis_tdata_i != expected);
  assign keep_bad = (s_axis_tkeep_i != AXIS_TKEEP);
  assign last_bad = (s_axis_tlast_i != is_final);

  // Beat checking and statistics; clear wins over an accepted beat in the same cycle.
  always_comb begin
    beat_idx_d = beat_idx_q;
    pkt_cnt_d  = pkt_cnt_q;
    data_err_d = data_err_q;
    last_err_d = last_err_q;
    keep_err_d = keep_err_q;
    error_d    = error_q;
    fe_exp_d   = fe_exp_q;
    fe_rcv_d   = fe_rcv_q;
    fe_pkt_d   = fe_pkt_q;
    if (clear_i) begin
      beat_idx_d = '0;
      pkt_cnt_d  = '0;
      data_err_d = '0;
      last_err_d = '0;
      keep_err_d = '0;
      error_d    = 1'b0;
      fe_exp_d   = '0;
      fe_rcv_d   = '0;
      fe_pkt_d   = '0;
    end else if (accept) begin
      if (data_bad) data_err_d = sat_inc(data_err_q);
      if (keep_bad) keep_err_d = sat_inc(keep_err_q);
      if (last_bad) last_err_d = sat_inc(last_err_q);
      if ((data_bad || keep_bad || last_bad) && !error_q) begin
        error_d  = 1'b1;
        fe_exp_d = expected;
        fe_rcv_d = s_axis_tdata_i;
        fe_pkt_d = pkt_cnt_q;
      end
      // An early tlast closes the packet too, so the next beat is expected to restart at 0.
      if (s_axis_tlast_i || is_final) begin
        beat_idx_d = '0;
        pkt_cnt_d  = sat_inc(pkt_cnt_q);
      end else begin
        beat_idx_d = beat_idx_q + IDX_W'(1);
      end
    end
  end

  // State, handshake and statistics registers.
  always_ff @(posedge clk_i) begin
    if (s_rst_i) begin
      state_q    <= ST_IDLE;
      tready_q   <= 1'b0;
      beat_idx_q <= '0;
      pkt_cnt_q  <= '0;
      data_err_q <= '0;
      last_err_q <= '0;
      keep_err_q <= '0;
      error_q    <= 1'b0;
      fe_exp_q   <= '0;
      fe_rcv_q   <= '0;
      fe_pkt_q   <= '0;
    end else begin
      state_q    <= state_d;
      tready_q   <= tready_d;
      beat_idx_q <= beat_idx_d;
      pkt_cnt_q  <= pkt_cnt_d;
      data_err_q <= data_err_d;
      last_err_q <= last_err_d;
      keep_err_q <= keep_err_d;
      error_q    <= error_d;
      fe_exp_q   <= fe_exp_d;
      fe_rcv_q   <= fe_rcv_d;
      fe_pkt_q   <= fe_pkt_d;
    end
  end

  assign s_axis_tready_o      = tready_q;
  assign packet_count_o       = pkt_cnt_q;
  assign data_err_count_o     = data_err_q;
  assign last_err_count_o     = last_err_q;
  assign keep_err_count_o     = keep_err_q;
  assign error_o              = error_q;
  assign first_err_expected_o = fe_exp_q;
  assign first_err_received_o = fe_rcv_q;
  assign first_err_packet_o   = fe_pkt_q;

endmodule
